axi_lite_reg_slave: RTL

AXI4-Lite slave (responder) register bank, the target-side counterpart of the SPI-bridge AXI4-Lite master. It accepts single-beat writes and reads on an AXI4-Lite slave port. It exposes C_NUM_REGS-1 read/write control registers and one read-only status word to user logic. It is used as the bench target for the bridge master and as a control-register block in the SoC fabric.

---
 rtl/axi_lite_pkg.sv | 13 +
 rtl/axi_lite_reg_bank.sv | 60 ++++++
 rtl/axi_lite_reg_slave.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite register slave.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte offset bits below the word index.
  localparam int ADDR_LSB = 2;

  typedef enum logic { W_IDLE, W_RESP } wstate_e;
  typedef enum logic { R_IDLE, R_DATA } rstate_e;

endpackage

// File: rtl/axi_lite_reg_bank.sv
// Byte-strobed control register array with write pulses and read mux.
// The top word is the read-only status word and has no storage here.
module axi_lite_reg_bank #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/8-1:0]        wr_strb,
  input  logic [IDX_W-1:0]           rd_idx,
  input  logic [DATA_W-1:0]          status_in,
  output logic [DATA_W-1:0]          rd_data,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  output logic [NUM_REGS-1:0]        reg_wr_pulse
);

  logic [NUM_REGS-2:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]             pulse_q, pulse_d;

  // Next register contents and write strobes; wr_en is already range-qualified.
  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    for (int k = 0; k < NUM_REGS - 1; k++) begin
      if (wr_en && (wr_idx == IDX_W'(k))) begin
        pulse_d[k] = 1'b1;
        for (int b = 0; b < DATA_W / 8; b++) begin
          if (wr_strb[b]) regs_d[k][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  // Register storage and pulse flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q  <= '0;
      pulse_q <= '0;
    end else begin
      regs_q  <= regs_d;
      pulse_q <= pulse_d;
    end
  end

  // Read mux: any index without storage falls through to the status word.
  always_comb begin
    rd_data = status_in;
    for (int k = 0; k < NUM_REGS - 1; k++) begin
      if (rd_idx == IDX_W'(k)) rd_data = regs_q[k];
    end
  end

  assign reg_out      = {{DATA_W{1'b0}}, regs_q};
  assign reg_wr_pulse = pulse_q;

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave register bank: independent write and read handshake FSMs
// in front of a byte-strobed control register array.
import axi_lite_pkg::*;

module axi_lite_reg_slave #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_REGS         = 8
) (
  input  logic                                 S_AXI_ACLK,
  input  logic                                 S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                           S_AXI_AWPROT,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                           S_AXI_ARPROT,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [C_NUM_REGS-1:0]                reg_wr_pulse,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        status_in
);

  localparam int IDX_W  = $clog2(C_NUM_REGS);
  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = DW / 8;
  localparam int AW     = C_S_AXI_ADDR_WIDTH;

  // Held low through reset so every READY output is 0 until the first clock after release.
  logic ready_en_q;

  wstate_e                 wstate_q, wstate_d;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic [AW-1:ADDR_LSB]    awaddr_q, awaddr_d;
  logic [DW-1:0]           wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;

  rstate_e                 rstate_q, rstate_d;
  logic                    rvalid_q, rvalid_d;
  logic [DW-1:0]           rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;

  logic [IDX_W-1:0]        wr_idx, rd_idx;
  logic                    wr_oor, rd_oor, wr_ok, wr_commit;
  logic [DW-1:0]           bank_rd_data;
  logic                    unused_inputs;

  assign wr_idx    = awaddr_q[ADDR_LSB +: IDX_W];
  assign wr_oor    = |awaddr_q[AW-1:ADDR_LSB+IDX_W];
  assign wr_ok     = !wr_oor && (wr_idx != IDX_W'(C_NUM_REGS - 1));
  assign wr_commit = (wstate_q == W_IDLE) && aw_held_q && w_held_q;

  assign rd_idx    = S_AXI_ARADDR[ADDR_LSB +: IDX_W];
  assign rd_oor    = |S_AXI_ARADDR[AW-1:ADDR_LSB+IDX_W];

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  assign S_AXI_AWREADY = ready_en_q && (wstate_q == W_IDLE) && !aw_held_q;
  assign S_AXI_WREADY  = ready_en_q && (wstate_q == W_IDLE) && !w_held_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = ready_en_q && (rstate_q == R_IDLE);
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  axi_lite_reg_bank #(
    .DATA_W   (DW),
    .NUM_REGS (C_NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk          (S_AXI_ACLK),
    .rst_n        (S_AXI_ARESETN),
    .wr_en        (wr_commit && wr_ok),
    .wr_idx       (wr_idx),
    .wr_data      (wdata_q),
    .wr_strb      (wstrb_q),
    .rd_idx       (rd_idx),
    .status_in    (status_in),
    .rd_data      (bank_rd_data),
    .reg_out      (reg_out),
    .reg_wr_pulse (reg_wr_pulse)
  );

  // Write FSM: capture AW and W independently, commit once both are held, then hold B.
  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (wstate_q)
      W_IDLE: begin
        if (wr_commit) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
          wstate_d  = W_RESP;
        end else begin
          if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            aw_held_d = 1'b1;
            awaddr_d  = S_AXI_AWADDR[AW-1:ADDR_LSB];
          end
          if (S_AXI_WVALID && S_AXI_WREADY) begin
            w_held_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d = 1'b0;
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Read FSM: load RDATA/RRESP on the AR handshake and hold them until R completes.
  always_comb begin
    rstate_d = rstate_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (S_AXI_ARVALID && S_AXI_ARREADY) begin
          rvalid_d = 1'b1;
          rdata_d  = rd_oor ? '0 : bank_rd_data;
          rresp_d  = rd_oor ? RESP_SLVERR : RESP_OKAY;
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d = 1'b0;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // State and handshake registers for both channels.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ready_en_q <= 1'b0;
      wstate_q   <= W_IDLE;
      aw_held_q  <= 1'b0;
      awaddr_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rstate_q   <= R_IDLE;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      ready_en_q <= 1'b1;
      wstate_q   <= wstate_d;
      aw_held_q  <= aw_held_d;
      awaddr_q   <= awaddr_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rstate_q   <= rstate_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule
